uart9_tx_frame_sched: RTL

Transmit-side frame scheduler for the 9-bit UART (`uart9`).
- Arbitrates between two message requesters and serialises the granted message into the framed byte stream the RX decoder understands: START control word, head byte, byte count, data bytes, END control word.
- Drives the UART transmitter load handshake itself, so requesters only present a head, a length and indexed data.

---
 rtl/uart9_tx_frame_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart9_tx_frame_sched.sv
// uart9_tx_frame_sched: round-robin frame scheduler feeding framed 9-bit words to uart9
module uart9_tx_frame_sched #(
    parameter int         DATAMAXBYTES = 10,
    parameter int         ACK_TIMEOUT  = 255,
    parameter logic [7:0] SP_START     = 8'h7E,
    parameter logic [7:0] SP_END       = 8'h7D
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [7:0] head0,
    input  logic [7:0] head1,
    input  logic [7:0] len0,
    input  logic [7:0] len1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] grant,
    output logic [3:0] data_idx,
    output logic [1:0] done,
    output logic       err,
    output logic       busy,
    output logic       tx_enable,
    output logic       ld_tx_data,
    output logic [8:0] tx_data,
    input  logic       tx_empty
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} stateT;
    typedef enum logic [2:0] {PH_START, PH_HEAD, PH_BCNT, PH_DATA, PH_END} phaseT;

    stateT      state, stateNext;
    phaseT      phase, phaseNext;
    logic [7:0] headReg, headNext;
    logic [7:0] lenReg, lenNext;
    logic [7:0] ackCnt, ackCntNext;
    logic       last, lastNext;
    logic       lastSent, lastSentNext;
    logic [1:0] grantNext, doneNext;
    logic [3:0] idxNext;
    logic       errNext;
    logic [8:0] wordNext, txDataNext;
    logic [1:0] winner;
    logic [7:0] lenSel, lenClamp, dataSel;
    logic       lastWord;

    // Arbitration: a lone request wins, a tie goes to whoever did not own the previous frame
    assign winner   = req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
    assign lenSel   = winner[1] ? len1 : len0;
    assign lenClamp = lenSel > 8'(DATAMAXBYTES) ? 8'(DATAMAXBYTES) : lenSel;
    assign dataSel  = grant[1] ? data1 : data0;
    assign lastWord = {4'd0, data_idx} == lenReg - 8'd1;

    // Next-state, field sequencing and the word to load on the next LOAD entry
    always_comb begin
        stateNext    = state;
        phaseNext    = phase;
        grantNext    = grant;
        idxNext      = data_idx;
        headNext     = headReg;
        lenNext      = lenReg;
        lastNext     = last;
        lastSentNext = lastSent;
        ackCntNext   = ackCnt;
        doneNext     = 2'b00;
        errNext      = 1'b0;
        case (state)
            IDLE: begin
                if (tx_empty && req != 2'b00) begin
                    stateNext = LOAD;
                    phaseNext = PH_START;
                    grantNext = winner;
                    headNext  = winner[1] ? head1 : head0;
                    lenNext   = lenClamp;
                    idxNext   = 4'd0;
                    lastNext  = winner[1];
                end
            end
            LOAD: begin
                stateNext  = WAIT_ACK;
                ackCntNext = 8'd0;
            end
            WAIT_ACK: begin
                if (!tx_empty) begin
                    stateNext    = WAIT_DONE;
                    lastSentNext = lastWord;
                    // the word is already latched, so step the index now to let the next byte settle before LOAD
                    if (phase == PH_DATA && !lastWord)
                        idxNext = data_idx + 4'd1;
                end else if (ackCnt == 8'(ACK_TIMEOUT - 1)) begin
                    stateNext = IDLE;
                    grantNext = 2'b00;
                    errNext   = 1'b1;
                end else begin
                    ackCntNext = ackCnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (tx_empty) begin
                    if (phase == PH_END) begin
                        stateNext = IDLE;
                        grantNext = 2'b00;
                        doneNext  = grant;
                    end else begin
                        stateNext = LOAD;
                        phaseNext = phase == PH_START ? PH_HEAD :
                                    phase == PH_HEAD  ? PH_BCNT :
                                    phase == PH_BCNT  ? (lenReg != 8'd0 ? PH_DATA : PH_END) :
                                    lastSent          ? PH_END : PH_DATA;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        wordNext   = phaseNext == PH_START ? {1'b1, SP_START} :
                     phaseNext == PH_HEAD  ? {1'b0, headReg} :
                     phaseNext == PH_BCNT  ? {1'b0, lenReg} :
                     phaseNext == PH_DATA  ? {1'b0, dataSel} : {1'b1, SP_END};
        txDataNext = stateNext == LOAD ? wordNext : tx_data;
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= PH_START;
            headReg    <= 8'd0;
            lenReg     <= 8'd0;
            ackCnt     <= 8'd0;
            last       <= 1'b1;
            lastSent   <= 1'b0;
            grant      <= 2'b00;
            data_idx   <= 4'd0;
            done       <= 2'b00;
            err        <= 1'b0;
            busy       <= 1'b0;
            tx_enable  <= 1'b0;
            ld_tx_data <= 1'b0;
            tx_data    <= 9'd0;
        end else begin
            state      <= stateNext;
            phase      <= phaseNext;
            headReg    <= headNext;
            lenReg     <= lenNext;
            ackCnt     <= ackCntNext;
            last       <= lastNext;
            lastSent   <= lastSentNext;
            grant      <= grantNext;
            data_idx   <= idxNext;
            done       <= doneNext;
            err        <= errNext;
            busy       <= stateNext != IDLE;
            tx_enable  <= stateNext != IDLE;
            ld_tx_data <= stateNext == LOAD;
            tx_data    <= txDataNext;
        end
    end
endmodule
